// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
package stopwatch_pkg;

  localparam int DIGIT_W = 5;
  localparam int BCD_W   = 4;

  localparam logic [BCD_W-1:0] UNITS_MAX = 4'd9;
  localparam logic [BCD_W-1:0] TENS_MAX  = 4'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    ADJUST = 2'd3
  } state_e;

  function automatic logic [DIGIT_W-1:0] to_digit(
    input logic [BCD_W-1:0] d
  );
    return DIGIT_W'(d);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control/display bundle between the input conditioning, the controller
// and the display multiplexer.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic               tick_1hz;
  logic               tick_2hz;
  logic               btn_pause;
  logic               btn_reset;
  logic               adj;
  logic               sel;
  logic [DIGIT_W-1:0] min_l;
  logic [DIGIT_W-1:0] min_r;
  logic [DIGIT_W-1:0] sec_l;
  logic [DIGIT_W-1:0] sec_r;
  logic               adj_active;
  logic               blink_on;
  logic               wrap;

  modport master (
    output tick_1hz, tick_2hz, btn_pause,
    output btn_reset, adj, sel,
    input  min_l, min_r, sec_l, sec_r,
    input  adj_active, blink_on, wrap
  );

  modport slave (
    input  tick_1hz, tick_2hz, btn_pause,
    input  btn_reset, adj, sel,
    output min_l, min_r, sec_l, sec_r,
    output adj_active, blink_on, wrap
  );

endinterface

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with synchronous clear and
// combinational carry out on the 59 -> 00 increment.
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] units,
  output logic             carry
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] units_q, units_d;
  logic             units_top, tens_top;

  assign units_top = (units_q == UNITS_MAX);
  assign tens_top  = (tens_q == TENS_MAX);
  assign carry     = inc & units_top & tens_top;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (inc) begin
      if (units_top) begin
        units_d = '0;
        tens_d  = tens_top ? '0 : tens_q + 1'b1;
      end else begin
        units_d = units_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/adjust sequencer driving four BCD digits.
// STOPWATCH_ROLLOVER_EN: wrap 59:59 -> 00:00 in RUN instead of halting.
module stopwatch_ctrl
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_PAUSE  = PAUSE;
  localparam logic [1:0] S_ADJUST = ADJUST;

  logic [1:0]       state_q, state_d;
  logic             blink_q, blink_d;
  logic             adj_q;
  logic             in_adj, running;
  logic             do_enter, do_exit, do_adj;
  logic             do_pause, adv;
  logic             sec_adj, min_adj;
  logic             sec_inc, min_inc;
  logic             sec_carry, min_carry;
  logic             at_max;
  logic [BCD_W-1:0] sec_t, sec_u, min_t, min_u;

  assign in_adj  = (state_q == S_ADJUST);
  assign running = (state_q == S_RUN);

  // One-hot action selects, priority: reset > adj > pause > ticks
  assign do_enter = ~bus.btn_reset & bus.adj & ~in_adj;
  assign do_exit  = ~bus.btn_reset & ~bus.adj & in_adj;
  assign do_adj   = ~bus.btn_reset & bus.adj & in_adj;
  assign do_pause = ~bus.btn_reset & ~bus.adj & ~in_adj
                  & bus.btn_pause;
  assign adv      = ~bus.btn_reset & ~bus.adj & running
                  & bus.tick_1hz;

  assign sec_adj = do_adj & bus.tick_2hz & bus.sel;
  assign min_adj = do_adj & bus.tick_2hz & ~bus.sel;

  assign at_max = (sec_t == TENS_MAX) & (sec_u == UNITS_MAX)
                & (min_t == TENS_MAX) & (min_u == UNITS_MAX);

`ifdef STOPWATCH_ROLLOVER_EN
  assign sec_inc = sec_adj | adv;
`else
  assign sec_inc = sec_adj | (adv & ~at_max);
`endif
  assign min_inc = min_adj | (adv & sec_carry);

  always_comb begin
    state_d = state_q;
    blink_d = 1'b1;
    unique case (1'b1)
      bus.btn_reset: state_d = S_IDLE;
      do_enter:      state_d = S_ADJUST;
      do_exit:       state_d = S_PAUSE;
      do_adj:        blink_d = blink_q ^ bus.tick_2hz;
      do_pause:      state_d = running ? S_PAUSE : S_RUN;
      default:       ;
    endcase
`ifndef STOPWATCH_ROLLOVER_EN
    if (adv && at_max) state_d = S_PAUSE;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blink_q <= 1'b1;
      adj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      adj_q   <= (state_d == S_ADJUST);
    end
  end

`ifdef STOPWATCH_ROLLOVER_EN
  logic wrap_q;

  always_ff @(posedge clk) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= adv & min_carry;
  end

  assign bus.wrap = wrap_q;
`else
  logic unused_min_carry;

  assign unused_min_carry = min_carry;
  assign bus.wrap         = 1'b0;
`endif

  bcd_mod60 u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.btn_reset),
    .inc   (sec_inc),
    .tens  (sec_t),
    .units (sec_u),
    .carry (sec_carry)
  );

  bcd_mod60 u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.btn_reset),
    .inc   (min_inc),
    .tens  (min_t),
    .units (min_u),
    .carry (min_carry)
  );

  assign bus.min_l      = to_digit(min_t);
  assign bus.min_r      = to_digit(min_u);
  assign bus.sec_l      = to_digit(sec_t);
  assign bus.sec_r      = to_digit(sec_u);
  assign bus.adj_active = adj_q;
  assign bus.blink_on   = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomized bench for stopwatch_ctrl against a
// seconds-count reference model.
module tb_stopwatch_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ADJ   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_mode = M_IDLE;
  int m_min  = 0;
  int m_sec  = 0;
  bit m_blink = 1'b1;
  bit m_wrap  = 1'b0;

  task automatic chk(string tag, int obs, int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic advance();
    int total;
    total = m_min * 60 + m_sec + 1;
    if (total == 3600) begin
`ifdef STOPWATCH_ROLLOVER_EN
      total  = 0;
      m_wrap = 1'b1;
`else
      total  = 3599;
      m_mode = M_PAUSE;
`endif
    end
    m_min = total / 60;
    m_sec = total % 60;
  endtask

  task automatic model(bit p, bit r, bit t1, bit t2,
                       bit a, bit s, bit rn);
    int old;
    m_wrap = 1'b0;
    if (!rn) begin
      m_mode = M_IDLE; m_min = 0; m_sec = 0; m_blink = 1'b1;
    end else if (r) begin
      m_mode = M_IDLE; m_min = 0; m_sec = 0; m_blink = 1'b1;
    end else if (a && m_mode != M_ADJ) begin
      m_mode = M_ADJ; m_blink = 1'b1;
    end else if (!a && m_mode == M_ADJ) begin
      m_mode = M_PAUSE; m_blink = 1'b1;
    end else if (m_mode == M_ADJ) begin
      if (t2) begin
        if (s) m_sec = (m_sec + 1) % 60;
        else   m_min = (m_min + 1) % 60;
        m_blink = ~m_blink;
      end
    end else begin
      old = m_mode;
      if (old == M_RUN && t1) advance();
      if (p) m_mode = (old == M_RUN) ? M_PAUSE : M_RUN;
      m_blink = 1'b1;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".min_l"}, int'(bus.min_l), m_min / 10);
    chk({tag, ".min_r"}, int'(bus.min_r), m_min % 10);
    chk({tag, ".sec_l"}, int'(bus.sec_l), m_sec / 10);
    chk({tag, ".sec_r"}, int'(bus.sec_r), m_sec % 10);
    chk({tag, ".adj_active"}, int'(bus.adj_active),
        int'(m_mode == M_ADJ));
    chk({tag, ".blink_on"}, int'(bus.blink_on), int'(m_blink));
    chk({tag, ".wrap"}, int'(bus.wrap), int'(m_wrap));
  endtask

  task automatic step(string tag, bit p, bit r, bit t1, bit t2);
    bus.btn_pause = p;
    bus.btn_reset = r;
    bus.tick_1hz  = t1;
    bus.tick_2hz  = t2;
    @(posedge clk);
    model(p, r, t1, t2, bus.adj, bus.sel, rst_n);
    #1;
    check_all(tag);
    bus.btn_pause = 1'b0;
    bus.btn_reset = 1'b0;
    bus.tick_1hz  = 1'b0;
    bus.tick_2hz  = 1'b0;
  endtask

  task automatic chk_time(string tag, int mm, int ss);
    chk({tag, ".mm"}, int'(bus.min_l) * 10 + int'(bus.min_r), mm);
    chk({tag, ".ss"}, int'(bus.sec_l) * 10 + int'(bus.sec_r), ss);
  endtask

  task automatic preload(int mm, int ss);
    step("pre_clr", 0, 1, 0, 0);
    bus.adj = 1'b1; bus.sel = 1'b0;
    step("pre_enter", 0, 0, 0, 0);
    for (int i = 0; i < mm; i++) step("pre_min", 0, 0, 0, 1);
    bus.sel = 1'b1;
    for (int i = 0; i < ss; i++) step("pre_sec", 0, 0, 0, 1);
    bus.adj = 1'b0;
    step("pre_exit", 0, 0, 0, 0);
  endtask

  initial begin
    bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0;
    bus.btn_pause = 1'b0; bus.btn_reset = 1'b0;
    bus.adj = 1'b0; bus.sel = 1'b0;

    rst_n = 1'b0;
    step("reset", 0, 0, 1, 0);
    step("reset", 1, 0, 1, 0);
    chk_time("reset_time", 0, 0);
    chk("reset_blink", int'(bus.blink_on), 1);
    rst_n = 1'b1;

    step("start", 1, 0, 0, 0);
    for (int i = 0; i < 75; i++) step("run75", 0, 0, 1, 0);
    chk_time("run75_time", 1, 15);
    chk("run75_adj", int'(bus.adj_active), 0);

    preload(59, 58);
    step("go", 1, 0, 0, 0);
    step("t5959", 0, 0, 1, 0);
    chk_time("t5959_time", 59, 59);
    step("edge", 0, 0, 1, 0);
`ifdef STOPWATCH_ROLLOVER_EN
    chk_time("roll_time", 0, 0);
    chk("roll_wrap", int'(bus.wrap), 1);
    step("roll_after", 0, 0, 0, 0);
    chk("roll_wrap_off", int'(bus.wrap), 0);
    step("roll_run", 0, 0, 1, 0);
    chk_time("roll_run_time", 0, 1);
`else
    chk_time("hold_time", 59, 59);
    chk("hold_wrap", int'(bus.wrap), 0);
    step("hold_paused", 0, 0, 1, 0);
    chk_time("hold_paused_time", 59, 59);
`endif

    step("clr", 0, 1, 0, 0);
    step("start12", 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step("run12", 0, 0, 1, 0);
    bus.adj = 1'b1; bus.sel = 1'b0;
    step("adj_enter", 0, 0, 1, 0);
    chk("blink_seq0", int'(bus.blink_on), 1);
    step("adj_m", 0, 0, 0, 1);
    chk("blink_seq1", int'(bus.blink_on), 0);
    step("adj_m", 0, 0, 1, 1);
    chk("blink_seq2", int'(bus.blink_on), 1);
    step("adj_m", 0, 0, 0, 1);
    chk("blink_seq3", int'(bus.blink_on), 0);
    bus.adj = 1'b0;
    step("adj_exit", 0, 0, 0, 0);
    chk_time("adj_exit_time", 3, 12);
    step("paused", 0, 0, 1, 0);
    chk_time("paused_time", 3, 12);

    preload(0, 58);
    bus.adj = 1'b1; bus.sel = 1'b1;
    step("sec_enter", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("sec_adj", 0, 0, 0, 1);
    chk_time("sec_nocarry", 0, 1);
    bus.adj = 1'b0;
    step("sec_exit", 0, 0, 0, 0);

    step("clr2", 0, 1, 0, 0);
    step("start9", 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("run9", 0, 0, 1, 0);
    step("pt_run", 1, 0, 1, 0);
    chk_time("pt_run_time", 0, 10);
    step("pt_chk_pause", 0, 0, 1, 0);
    chk_time("pt_pause_time", 0, 10);
    step("pt_pause", 1, 0, 1, 0);
    chk_time("pt_pause2_time", 0, 10);
    step("pt_chk_run", 0, 0, 1, 0);
    chk_time("pt_run2_time", 0, 11);

    preload(12, 34);
    step("go1234", 1, 0, 0, 0);
    bus.adj = 1'b1;
    step("rst_all", 0, 1, 1, 0);
    chk_time("rst_all_time", 0, 0);
    bus.adj = 1'b0;
    step("rst_idle", 0, 0, 1, 0);
    chk_time("rst_idle_time", 0, 0);

    step("start_r", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("run_r", 0, 0, 1, 0);
    rst_n = 1'b0;
    step("midrst", 1, 0, 1, 1);
    chk_time("midrst_time", 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(99) != 0);
      if ($urandom_range(19) == 0) bus.adj = ~bus.adj;
      if ($urandom_range(9) == 0)  bus.sel = ~bus.sel;
      step("rand",
           $urandom_range(9) == 0,
           $urandom_range(39) == 0,
           $urandom_range(9) < 3,
           $urandom_range(9) < 3);
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
